output_feature_writer: RTL and testbench
========================================

Name: output_feature_writer

Overview:
- Sits directly upstream of the output feature BRAM bank set, ahead of the output address decode path.
- Accepts a stream of post-accumulation output pixels. Each beat carries one value per output BRAM, i.e. 4 consecutive channels at the same (row, col).
- Walks col, then row, then channel group for one output tile. Generates the BRAM address and per-bank write enables with the team's group-major layout: address = ((ch - start) >> 2) * ROW * COL + row * COL + col.
- Uses incremental adders instead of multipliers.

Parameters:
- OUTPUT_CHANNEL_WIDTH, 8, width of channel indices.
- OUTPUT_ROW_WIDTH, 6, width of row count and row index.
- OUTPUT_COL_WIDTH, 6, width of column count and column index.
- OUTPUT_BRAM_NUM, 4, number of output BRAMs (channel lanes per beat); fixed power of 2.
- OUTPUT_BRAM_DEPTH, 1152, words per BRAM.
- OUTPUT_BRAM_ADDRESS_WIDTH, $clog2(OUTPUT_BRAM_DEPTH), BRAM address width.
- DATA_WIDTH, 16, width of one output feature value.

Ports:
- i_clk  input  1  clock; all logic on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  single-cycle pulse that begins a tile; ignored unless idle.
- i_output_feature_row  input  OUTPUT_ROW_WIDTH  tile row count R; sampled on i_start.
- i_output_feature_col  input  OUTPUT_COL_WIDTH  tile column count C; sampled on i_start.
- i_output_start_index_channel  input  OUTPUT_CHANNEL_WIDTH  first channel; sampled on i_start.
- i_output_end_index_channel  input  OUTPUT_CHANNEL_WIDTH  last channel, inclusive; sampled on i_start.
- i_data_valid  input  1  input beat valid.
- o_data_ready  output  1  block can accept a beat.
- i_data  input  OUTPUT_BRAM_NUM*DATA_WIDTH  lane k holds channel (group base + k).
- o_bram_we  output  OUTPUT_BRAM_NUM  per-bank write enable.
- o_bram_addr  output  OUTPUT_BRAM_ADDRESS_WIDTH  shared write address.
- o_bram_wdata  output  OUTPUT_BRAM_NUM*DATA_WIDTH  lane-aligned write data.
- o_busy  output  1  tile in progress.
- o_done  output  1  one-cycle pulse when the tile completes.

Behaviour:
- Reset (async, i_rst_n=0): FSM to IDLE.
  - o_data_ready, o_bram_we, o_busy, o_done, o_bram_addr, o_bram_wdata all 0.
  - All counters 0.
  - Reset mid-tile abandons the tile with no further writes and no o_done.
- FSM states IDLE, RUN, DONE.
- IDLE:
  - On i_start, latch R, C, start, end.
  - Compute N = end - start + 1 and groups G = ceil(N/4).
  - Register plane = R*C (one multiply at setup, or a registered adder loop). Plane must settle before the first write.
  - If R==0, C==0, or end<start: go to DONE with no writes. Otherwise go to RUN.
- RUN:
  - o_data_ready=1, o_busy=1. A beat is accepted when i_data_valid && o_data_ready.
  - On accept, advance col. At col==C-1, wrap col to 0 and advance row, and add C to the row base. At row==R-1, wrap row and advance group, and add plane to the group base.
  - Address = group_base + row_base + col; truncate to OUTPUT_BRAM_ADDRESS_WIDTH. The caller guarantees G*R*C <= OUTPUT_BRAM_DEPTH.
  - Accept on the last beat of the last group goes to DONE.
- Write timing: o_bram_we, o_bram_addr, o_bram_wdata are registered, so a write appears exactly 1 cycle after its accept.
  - With no accept, o_bram_we=0 the next cycle; addr and wdata hold.
- Lane mask: o_bram_we[k]=1 only if group*4 + k < N, so the final group masks lanes beyond end.
- DONE: o_data_ready=0.
  - o_done=1 for exactly one cycle; this is the cycle after the last write, or the cycle after i_start for a degenerate tile.
  - Then IDLE, with o_busy=0.
- i_data_valid gaps are allowed at any point and stall the counters.
- i_start while in RUN or DONE is ignored.

Test Plan:
- R=4, C=4, start=0, end=7; 32 back-to-back beats -> addresses 0..31 in order, we=1111 on every write, o_done pulse 1 cycle after the write to addr 31, o_busy drops the same cycle.
- R=3, C=5, start=0, end=5 -> beats 0..14 write addr 0..14 with we=1111; beats 15..29 write addr 15..29 with we=0011.
- R=2, C=2, start=8, end=11, valid toggling 1,0,1,0 -> 4 writes at addr 0..3, each 1 cycle after its accept; no write in gap cycles.
- start=5, end=4 (or R=0) -> no o_bram_we assertion, o_done one cycle after i_start, o_data_ready stays 0.
- Assert i_rst_n=0 after 10 beats of a 32-beat tile -> all outputs 0 immediately; a new i_start then begins again at addr 0.
- Pulse i_start again mid-RUN with different R/C -> ignored; the original address sequence completes unchanged.

Source files
------------

// File: rtl/output_feature_writer.sv
// Output feature BRAM write-address generator.
// Walks col/row/channel-group of one tile and issues lane-masked writes.
module output_feature_writer #(
    parameter int OUTPUT_CHANNEL_WIDTH      = 8,
    parameter int OUTPUT_ROW_WIDTH          = 6,
    parameter int OUTPUT_COL_WIDTH          = 6,
    parameter int OUTPUT_BRAM_NUM           = 4,
    parameter int OUTPUT_BRAM_DEPTH         = 1152,
    parameter int OUTPUT_BRAM_ADDRESS_WIDTH = $clog2(OUTPUT_BRAM_DEPTH),
    parameter int DATA_WIDTH                = 16
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_start,
    input  logic [OUTPUT_ROW_WIDTH-1:0]           i_output_feature_row,
    input  logic [OUTPUT_COL_WIDTH-1:0]           i_output_feature_col,
    input  logic [OUTPUT_CHANNEL_WIDTH-1:0]       i_output_start_index_channel,
    input  logic [OUTPUT_CHANNEL_WIDTH-1:0]       i_output_end_index_channel,
    input  logic                                  i_data_valid,
    output logic                                  o_data_ready,
    input  logic [OUTPUT_BRAM_NUM*DATA_WIDTH-1:0] i_data,
    output logic [OUTPUT_BRAM_NUM-1:0]            o_bram_we,
    output logic [OUTPUT_BRAM_ADDRESS_WIDTH-1:0]  o_bram_addr,
    output logic [OUTPUT_BRAM_NUM*DATA_WIDTH-1:0] o_bram_wdata,
    output logic                                  o_busy,
    output logic                                  o_done
);

    localparam int CW = OUTPUT_CHANNEL_WIDTH;
    localparam int RW = OUTPUT_ROW_WIDTH;
    localparam int KW = OUTPUT_COL_WIDTH;
    localparam int BN = OUTPUT_BRAM_NUM;
    localparam int AW = OUTPUT_BRAM_ADDRESS_WIDTH;
    localparam int DW = BN * DATA_WIDTH;
    localparam int NW = CW + 1;
    localparam int PW = RW + KW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   rows_q, rows_d;
    logic [KW-1:0]   cols_q, cols_d;
    logic [PW-1:0]   plane_q, plane_d;
    logic [RW-1:0]   row_q, row_d;
    logic [KW-1:0]   col_q, col_d;
    logic [NW-1:0]   rem_q, rem_d;
    logic [AW-1:0]   row_base_q, row_base_d;
    logic [AW-1:0]   grp_base_q, grp_base_d;
    logic [BN-1:0]   we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;

    logic            accept;
    logic            col_last;
    logic            row_last;
    logic            grp_last;
    logic            degen;
    logic            done;
    logic [NW-1:0]   n_total;
    logic [AW-1:0]   addr_now;
    logic [BN-1:0]   lane_en;

    assign accept   = (state_q == S_RUN) && i_data_valid;
    assign col_last = (col_q == (cols_q - KW'(1)));
    assign row_last = (row_q == (rows_q - RW'(1)));
    assign grp_last = (rem_q <= NW'(BN));
    assign n_total  = NW'(i_output_end_index_channel)
                    - NW'(i_output_start_index_channel) + NW'(1);
    assign degen    = (i_output_feature_row == '0)
                   || (i_output_feature_col == '0)
                   || (i_output_end_index_channel < i_output_start_index_channel);
    assign addr_now = grp_base_q + row_base_q + AW'(col_q);

    // Done only once the final registered write has left the output port
    assign done = (state_q == S_DONE) && (we_q == '0);

    assign o_data_ready = (state_q == S_RUN);
    assign o_busy       = (state_q != S_IDLE) && !done;
    assign o_done       = done;
    assign o_bram_we    = we_q;
    assign o_bram_addr  = addr_q;
    assign o_bram_wdata = wdata_q;

    // Lane k is live while at least k+1 channels remain in this group
    always_comb begin
        lane_en = '0;
        for (int k = 0; k < BN; k++) begin
            lane_en[k] = (rem_q > NW'(k));
        end
    end

    // Tile FSM next-state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = degen ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (accept && col_last && row_last && grp_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Tile geometry latch and incremental col/row/group address walk
    always_comb begin
        rows_d     = rows_q;
        cols_d     = cols_q;
        plane_d    = plane_q;
        row_d      = row_q;
        col_d      = col_q;
        rem_d      = rem_q;
        row_base_d = row_base_q;
        grp_base_d = grp_base_q;
        if ((state_q == S_IDLE) && i_start) begin
            rows_d     = i_output_feature_row;
            cols_d     = i_output_feature_col;
            plane_d    = PW'(i_output_feature_row) * PW'(i_output_feature_col);
            row_d      = '0;
            col_d      = '0;
            rem_d      = n_total;
            row_base_d = '0;
            grp_base_d = '0;
        end else if (accept) begin
            if (col_last) begin
                col_d = '0;
                if (row_last) begin
                    row_d      = '0;
                    row_base_d = '0;
                    grp_base_d = grp_base_q + AW'(plane_q);
                    rem_d      = rem_q - NW'(BN);
                end else begin
                    row_d      = row_q + RW'(1);
                    row_base_d = row_base_q + AW'(cols_q);
                end
            end else begin
                col_d = col_q + KW'(1);
            end
        end
    end

    // Registered write port; addr and data hold between writes
    always_comb begin
        we_d    = '0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (accept) begin
            we_d    = lane_en;
            addr_d  = addr_now;
            wdata_d = i_data;
        end
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter and write-port registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rows_q     <= '0;
            cols_q     <= '0;
            plane_q    <= '0;
            row_q      <= '0;
            col_q      <= '0;
            rem_q      <= '0;
            row_base_q <= '0;
            grp_base_q <= '0;
            we_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            rows_q     <= rows_d;
            cols_q     <= cols_d;
            plane_q    <= plane_d;
            row_q      <= row_d;
            col_q      <= col_d;
            rem_q      <= rem_d;
            row_base_q <= row_base_d;
            grp_base_q <= grp_base_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

endmodule

// File: tb/tb_output_feature_writer.sv
// Bench for output_feature_writer.
// Expected writes queued at drive time, checked as they emerge.
module tb_output_feature_writer;

    localparam int AW = 11;
    localparam int BN = 4;
    localparam int DW = 64;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [BN-1:0] we;
        logic [DW-1:0] data;
    } wr_t;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [5:0]    i_row = '0;
    logic [5:0]    i_col = '0;
    logic [7:0]    i_sch = '0;
    logic [7:0]    i_ech = '0;
    logic          i_data_valid = 1'b0;
    logic          o_data_ready;
    logic [DW-1:0] i_data = '0;
    logic [BN-1:0] o_bram_we;
    logic [AW-1:0] o_bram_addr;
    logic [DW-1:0] o_bram_wdata;
    logic          o_busy;
    logic          o_done;

    int  vectors = 0;
    int  errors = 0;
    wr_t sb[$];
    logic exp_wr;

    output_feature_writer dut (
        .i_clk                        (i_clk),
        .i_rst_n                      (i_rst_n),
        .i_start                      (i_start),
        .i_output_feature_row         (i_row),
        .i_output_feature_col         (i_col),
        .i_output_start_index_channel (i_sch),
        .i_output_end_index_channel   (i_ech),
        .i_data_valid                 (i_data_valid),
        .o_data_ready                 (o_data_ready),
        .i_data                       (i_data),
        .o_bram_we                    (o_bram_we),
        .o_bram_addr                  (o_bram_addr),
        .o_bram_wdata                 (o_bram_wdata),
        .o_busy                       (o_busy),
        .o_done                       (o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A write must appear exactly one cycle after each accept
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) exp_wr <= 1'b0;
        else          exp_wr <= i_data_valid && o_data_ready;
    end

    always @(negedge i_clk) begin
        wr_t e;
        if (i_rst_n) begin
            chk("wr_timing", DW'(|o_bram_we), DW'(exp_wr));
            if (exp_wr) begin
                chk("sb_avail", DW'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("addr", DW'(o_bram_addr), DW'(e.addr));
                    chk("we", DW'(o_bram_we), DW'(e.we));
                    chk("wdata", o_bram_wdata, e.data);
                end
            end
        end
    end

    task automatic run_tile(input int R, input int C, input int s, input int e,
                            input bit gaps, input int restart_at,
                            input int abort_at);
        int n;
        int ng;
        int total;
        int idx;
        bit aborted;
        wr_t w;
        n = e - s + 1;
        ng = (n + 3) / 4;
        total = ng * R * C;
        idx = 0;
        aborted = 1'b0;
        @(negedge i_clk);
        i_start = 1'b1;
        i_row = 6'(R);
        i_col = 6'(C);
        i_sch = 8'(s);
        i_ech = 8'(e);
        @(negedge i_clk);
        i_start = 1'b0;
        chk("busy_run", DW'(o_busy), 64'd1);
        chk("ready_run", DW'(o_data_ready), 64'd1);
        for (int g = 0; g < ng; g++) begin
            for (int r = 0; r < R; r++) begin
                for (int c = 0; c < C; c++) begin
                    if (idx == abort_at) aborted = 1'b1;
                    if (!aborted) begin
                        w.addr = AW'(g * R * C + r * C + c);
                        for (int k = 0; k < BN; k++)
                            w.we[k] = (g * 4 + k < n);
                        w.data = {$urandom, $urandom};
                        i_data = w.data;
                        i_data_valid = 1'b1;
                        if (idx == restart_at) begin
                            i_start = 1'b1;
                            i_row = 6'd2;
                            i_col = 6'd3;
                        end
                        sb.push_back(w);
                        @(negedge i_clk);
                        i_data_valid = 1'b0;
                        i_start = 1'b0;
                        if (gaps && idx != total - 1) @(negedge i_clk);
                        idx++;
                    end
                end
            end
        end
        if (aborted) begin
            #2 i_rst_n = 1'b0;
            #1;
            chk("rst_ready", DW'(o_data_ready), 64'd0);
            chk("rst_we", DW'(o_bram_we), 64'd0);
            chk("rst_addr", DW'(o_bram_addr), 64'd0);
            chk("rst_wdata", o_bram_wdata, 64'd0);
            chk("rst_busy", DW'(o_busy), 64'd0);
            chk("rst_done", DW'(o_done), 64'd0);
            sb.delete();
            @(negedge i_clk);
            i_rst_n = 1'b1;
        end else begin
            chk("done_early", DW'(o_done), 64'd0);
            chk("busy_last", DW'(o_busy), 64'd1);
            @(negedge i_clk);
            chk("done_pulse", DW'(o_done), 64'd1);
            chk("busy_drop", DW'(o_busy), 64'd0);
            chk("ready_done", DW'(o_data_ready), 64'd0);
            @(negedge i_clk);
            chk("done_clear", DW'(o_done), 64'd0);
            chk("sb_drained", DW'(sb.size()), 64'd0);
        end
    endtask

    task automatic run_degen(input int R, input int C, input int s,
                             input int e);
        @(negedge i_clk);
        i_start = 1'b1;
        i_row = 6'(R);
        i_col = 6'(C);
        i_sch = 8'(s);
        i_ech = 8'(e);
        @(negedge i_clk);
        i_start = 1'b0;
        chk("dg_done", DW'(o_done), 64'd1);
        chk("dg_ready", DW'(o_data_ready), 64'd0);
        chk("dg_we", DW'(o_bram_we), 64'd0);
        @(negedge i_clk);
        chk("dg_done_clr", DW'(o_done), 64'd0);
        chk("dg_ready2", DW'(o_data_ready), 64'd0);
        chk("dg_busy", DW'(o_busy), 64'd0);
    endtask

    initial begin
        #2;
        chk("reset_ready", DW'(o_data_ready), 64'd0);
        chk("reset_we", DW'(o_bram_we), 64'd0);
        chk("reset_addr", DW'(o_bram_addr), 64'd0);
        chk("reset_busy", DW'(o_busy), 64'd0);
        chk("reset_done", DW'(o_done), 64'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        run_tile(4, 4, 0, 7, 1'b0, -1, -1);
        run_tile(3, 5, 0, 5, 1'b0, -1, -1);
        run_tile(2, 2, 8, 11, 1'b1, -1, -1);
        run_degen(4, 4, 5, 4);
        run_degen(0, 4, 0, 3);
        run_degen(4, 0, 0, 3);
        run_tile(4, 4, 0, 7, 1'b0, -1, 10);
        run_tile(4, 4, 0, 7, 1'b0, -1, -1);
        run_tile(3, 4, 2, 9, 1'b0, 5, -1);
        run_tile(1, 1, 3, 3, 1'b1, -1, -1);
        repeat (3) @(negedge i_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
